// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 256-bit line memory port between an instruction
// line-fill requester and a data line requester. Simultaneous requests in
// IDLE are resolved round-robin against the side granted last. The line
// address, write data and direction are captured at grant so the memory sees
// stable values for the whole transaction. Per-side completion counters wrap.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [31:0]  i_addr,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_addr,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_addr,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp,
  output logic [15:0]  gnt_i_cnt,
  output logic [15:0]  gnt_d_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  // Clears the byte offset inside a 32-byte line.
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  state_t         state_r;
  state_t         state_nxt_s;
  logic           last_gnt_r;   // 0: I served last, 1: D served last
  logic           d_req_s;
  logic           gnt_i_s;
  logic           gnt_d_s;
  logic [31:0]    addr_r;
  logic [255:0]   wdata_r;
  logic           wr_r;
  logic [15:0]    i_cnt_r;
  logic [15:0]    d_cnt_r;

  assign d_req_s   = d_read | d_write;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign gnt_i_cnt = i_cnt_r;
  assign gnt_d_cnt = d_cnt_r;

  // Grant decision in IDLE (round-robin on a tie) and next-state selection.
  always_comb begin
    gnt_i_s     = 1'b0;
    gnt_d_s     = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_read && d_req_s) begin
          if (last_gnt_r) begin
            gnt_i_s = 1'b1;
          end else begin
            gnt_d_s = 1'b1;
          end
        end else if (i_read) begin
          gnt_i_s = 1'b1;
        end else if (d_req_s) begin
          gnt_d_s = 1'b1;
        end else begin
          gnt_i_s = 1'b0;
        end
        if (gnt_i_s) begin
          state_nxt_s = SERVE_I;
        end else if (gnt_d_s) begin
          state_nxt_s = SERVE_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVE_I;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVE_D;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Memory strobes and requester responses decoded from the serving state.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state_r)
      SERVE_I: begin
        mem_read = 1'b1;
        i_resp   = mem_resp;
      end
      SERVE_D: begin
        mem_read  = ~wr_r;
        mem_write = wr_r;
        d_resp    = mem_resp;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  // State register and round-robin pointer, updated on each grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      last_gnt_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (gnt_i_s) begin
        last_gnt_r <= 1'b0;
      end else if (gnt_d_s) begin
        last_gnt_r <= 1'b1;
      end else begin
        last_gnt_r <= last_gnt_r;
      end
    end
  end

  // Capture line address, write data and direction of the granted side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= 32'h0000_0000;
      wdata_r <= 256'd0;
      wr_r    <= 1'b0;
    end else if (gnt_i_s) begin
      addr_r  <= i_addr & LINE_MASK;
      wdata_r <= 256'd0;
      wr_r    <= 1'b0;
    end else if (gnt_d_s) begin
      addr_r  <= d_addr & LINE_MASK;
      wdata_r <= d_wdata;
      wr_r    <= d_write;   // a write wins when both read and write are raised
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wr_r    <= wr_r;
    end
  end

  // Completed-transaction counters, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt_r <= 16'h0000;
      d_cnt_r <= 16'h0000;
    end else begin
      if (i_resp) begin
        i_cnt_r <= i_cnt_r + 16'd1;
      end else begin
        i_cnt_r <= i_cnt_r;
      end
      if (d_resp) begin
        d_cnt_r <= d_cnt_r + 16'd1;
      end else begin
        d_cnt_r <= d_cnt_r;
      end
    end
  end

endmodule
